// File: rtl/hazard_detect_unit.sv
// ----------------------------------------------------------------------------
// hazard_detect_unit
//
// Purpose:
//   Data-hazard detection for a 5-stage in-order pipeline. A shadow copy of
//   the EX, MEM and WB destination information is kept here and compared
//   against the source registers of the instruction currently in ID. The block
//   either requests a pipeline stall (hold PC and IF/ID, bubble into EX) or
//   selects an operand bypass path. It also keeps a saturating count of stall
//   cycles.
//
// Configuration:
//   FORWARD_EN  defined   -> operands are bypassed from EX/MEM; only a
//                            load-use hazard stalls.
//               undefined -> no bypassing; any EX or MEM producer stalls the
//                            consumer until the value reaches the write-first
//                            register file (default build).
//
// Ports:
//   Clk          in   1   clock, rising edge
//   Rst          in   1   asynchronous active-high reset
//   DestReg      in   5   destination register of the ID instruction
//   RegWrite_ID  in   1   ID instruction writes DestReg
//   MemRead_ID   in   1   ID instruction is a load
//   Rs_ID        in   5   first source register of the ID instruction
//   Rt_ID        in   5   second source register of the ID instruction
//   UsesRs       in   1   ID instruction reads Rs_ID
//   UsesRt       in   1   ID instruction reads Rt_ID
//   Flush        in   1   squash the instruction leaving ID
//   Stall        out  1   hold PC and IF/ID, bubble into EX
//   ForwardA     out  2   Rs source: 00 regfile, 01 EX result, 10 MEM result
//   ForwardB     out  2   Rt source, same encoding
//   StallCount   out  16  saturating number of stall cycles
// ----------------------------------------------------------------------------
module hazard_detect_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  DestReg,
    input  logic        RegWrite_ID,
    input  logic        MemRead_ID,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic        UsesRs,
    input  logic        UsesRt,
    input  logic        Flush,
    output logic        Stall,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic [15:0] StallCount
);

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic [4:0] dest;
    } entry_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    entry_t      ex_q,  ex_d;
    entry_t      mem_q, mem_d;
    entry_t      wb_q,  wb_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        rs_ex_hit, rs_mem_hit;
    logic        rt_ex_hit, rt_mem_hit;
    logic        hazard;
    fwd_sel_e    fwd_a, fwd_b;

    // A stage supplies a source only if it holds a real instruction that
    // writes that register; $0 is hard-wired and never produced.
    function automatic logic src_match(input entry_t     e,
                                       input logic [4:0] src,
                                       input logic       uses);
        return e.valid && e.regwrite && (e.dest == src) &&
               (src != 5'd0) && uses;
    endfunction

    // Only EX and MEM are compared. The WB value is written into the register
    // file in the first half of the cycle, so the ID read already sees it.
    // The ID instruction itself is not in the shadow pipeline yet, so it can
    // never match its own destination.
    always_comb begin
        rs_ex_hit  = src_match(ex_q,  Rs_ID, UsesRs);
        rs_mem_hit = src_match(mem_q, Rs_ID, UsesRs);
        rt_ex_hit  = src_match(ex_q,  Rt_ID, UsesRt);
        rt_mem_hit = src_match(mem_q, Rt_ID, UsesRt);
    end

`ifdef FORWARD_EN
    // A load in EX has no data until the end of MEM, so its consumer waits
    // one cycle; everything else is bypassed, youngest producer first.
    always_comb begin
        hazard = ex_q.memread && (rs_ex_hit || rt_ex_hit);
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
        if (!hazard) begin
            if (rs_ex_hit) begin
                fwd_a = FWD_EX;
            end else if (rs_mem_hit) begin
                fwd_a = FWD_MEM;
            end
            if (rt_ex_hit) begin
                fwd_b = FWD_EX;
            end else if (rt_mem_hit) begin
                fwd_b = FWD_MEM;
            end
        end
    end
`else
    // Without bypassing the consumer waits until the producer reaches WB.
    always_comb begin
        hazard = rs_ex_hit || rs_mem_hit || rt_ex_hit || rt_mem_hit;
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
    end
`endif

    // A flushed instruction is discarded, so it never needs to wait. Rst is
    // folded in so a stall ends together with an asynchronous reset.
    always_comb begin
        Stall    = hazard && !Flush && !Rst;
        ForwardA = Rst ? FWD_RF : fwd_a;
        ForwardB = Rst ? FWD_RF : fwd_b;
    end

    always_comb begin
        ex_d = '0;
        if (!Stall && !Flush) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = RegWrite_ID;
            ex_d.memread  = MemRead_ID;
            ex_d.dest     = DestReg;
        end
        mem_d = ex_q;
        wb_d  = mem_q;

        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

    // Bubbles are always fully cleared, so an invalid entry can never carry
    // stale destination or control bits down the shadow pipeline.
    always_comb begin
        a_ex_bubble_clean:  assert (ex_q.valid  || (ex_q  == '0));
        a_mem_bubble_clean: assert (mem_q.valid || (mem_q == '0));
        a_wb_bubble_clean:  assert (wb_q.valid  || (wb_q  == '0));
    end

endmodule

// File: doc/hazard_detect_unit.md
HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- Clk  in  1  sole clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- DestReg  in  5  destination register of the instruction in ID, as chosen by the rt/rd destination select.
- RegWrite_ID  in  1  instruction in ID writes DestReg.
- MemRead_ID  in  1  instruction in ID is a load.
- Rs_ID  in  5  first source register of the instruction in ID.
- Rt_ID  in  5  second source register of the instruction in ID.
- UsesRs  in  1  instruction in ID reads Rs_ID.
- UsesRt  in  1  instruction in ID reads Rt_ID.
- Flush  in  1  taken branch or jump; squash the instruction leaving ID.
- Stall  out  1  hold PC and IF/ID; insert bubble into EX.
- ForwardA  out  2  Rs operand source: 00 register file, 01 EX result, 10 MEM result.
- ForwardB  out  2  Rt operand source, same encoding as ForwardA.
- StallCount  out  16  saturating count of stall cycles.

Function
REQ-002 The block SHALL keep a 3-entry shadow pipeline (EX, MEM, WB), each entry {valid, regwrite, memread, dest[4:0]}, advancing one stage per cycle with no stall input from downstream.
REQ-003 Each cycle, EX SHALL load {1, RegWrite_ID, MemRead_ID, DestReg} unless Stall or Flush is 1; in that case EX SHALL load a bubble (valid=0).
REQ-004 MEM SHALL load the old EX entry and WB SHALL load the old MEM entry every cycle, unconditionally.
REQ-005 An entry SHALL match source register S only if valid=1, regwrite=1, dest==S, S!=0, and the matching Uses* input is 1; register 0 SHALL never match.
REQ-006 Stall, ForwardA and ForwardB SHALL be combinational from the current entries and ID inputs, with zero-cycle latency.
REQ-007 The WB entry SHALL never cause a stall or forward, because the register file is write-first.
REQ-008 Flush=1 SHALL force Stall=0 in that cycle; a flushed instruction never stalls.
REQ-009 StallCount SHALL increment by 1 in every cycle with Stall=1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-010 When an ID instruction writes the same register it reads (e.g. Rs_ID==DestReg), the block SHALL check only older entries; the instruction SHALL not match itself.

Reset
REQ-011 While Rst=1, all three entries SHALL clear to valid=0 and dest=0, and StallCount SHALL clear to 0.
REQ-012 Stall SHALL be 0 and ForwardA/ForwardB SHALL be 00 during reset and in the first cycle after reset.
REQ-013 When reset is asserted in the middle of a stall, the stall SHALL end in the same cycle, with no further StallCount increment.

Configuration
REQ-014 Macro FORWARD_EN SHALL select the hazard policy.
REQ-015 With FORWARD_EN defined:
- Stall SHALL be 1 only for a load-use hazard, i.e. the EX entry has memread=1 and matches.
- Otherwise ForwardA/ForwardB SHALL be 01 for an EX match, or 10 for a MEM match (EX wins if both).
- A MEM-stage load match SHALL give 10.
REQ-016 Without FORWARD_EN:
- ForwardA/ForwardB SHALL be tied to 00.
- Stall SHALL be 1 whenever the EX or MEM entry matches, for at most 2 cycles per hazard.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset: Rst pulse mid-run -> Stall=0, Forward=00, StallCount=0 on the next edge.
- ALU back-to-back: add $8 then sub reading $8 as Rs -> FORWARD_EN: ForwardA=01, Stall=0. No FORWARD_EN: Stall high 2 cycles, StallCount +2.
- Load-use: lw $9 then add reading $9 as Rt -> FORWARD_EN: Stall=1 for 1 cycle, then ForwardB=10.
- Register $0: producer dest=0, consumer Rs=0 -> Stall=0, ForwardA=00 in both configurations.
- Flush with hazard: load-use condition plus Flush=1 -> Stall=0, EX loads a bubble, no later match.
- Saturation: Stall held for 70000 cycles -> StallCount stays at 16'hFFFF.
